// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CTRL_RD = 1;
    localparam int unsigned CTRL_WR = 0;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } lsu_state_t;

    // Captured access; only the low half of store data is needed for sub-word merges.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [15:0]     data_lo;
        logic [2:0]      funct3;
        logic            is_store;
    } lsu_req_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 <= F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd1:    return off[0];
            2'd2:    return (off != 2'd0);
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// Word-addressed data-memory port: request channel plus read-response channel.
interface mem_lsu_if;
    import mem_pkg::*;

    logic            valid;
    logic            ready;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational load extract/extend and sub-word store lane merge.
module mem_lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    input  logic [15:0]     wdata_lo,
    output logic [XLEN-1:0] load_c,
    output logic [XLEN-1:0] merge_c
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        load_c = rdata;
        case (funct3[1:0])
            2'd0:    load_c = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    load_c = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_c = rdata;
        endcase

        merge_c = rdata;
        case (funct3[1:0])
            2'd0: merge_c[{off, 3'b000} +: 8] = wdata_lo[7:0];
            2'd1: begin
                if (off[1]) merge_c[31:16] = wdata_lo;
                else        merge_c[15:0]  = wdata_lo;
            end
            default: merge_c = rdata;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns pipeline load/store controls into memory
// transactions, with read-modify-write for sub-word stores and a read timeout.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [XLEN-1:0] i_memAddr,
    input  logic [XLEN-1:0] i_writeData,
    input  logic [1:0]      i_ctrlMEM,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_readData,
    output logic            o_stall,
    output logic            o_fault,
    mem_lsu_if.master       mem
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    lsu_state_t      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            stall_c, fault_c;

    logic            one_hot, in_store, legal;
    logic [XLEN-1:0] load_c, merge_c;

    mem_lsu_align u_align (
        .funct3   (req_q.funct3),
        .off      (req_q.addr[1:0]),
        .rdata    (mem.rdata),
        .wdata_lo (req_q.data_lo),
        .load_c   (load_c),
        .merge_c  (merge_c)
    );

    assign one_hot  = ^i_ctrlMEM;
    assign in_store = i_ctrlMEM[CTRL_WR];
    assign legal    = one_hot && f3_legal(in_store, i_funct3) &&
                      !misaligned(i_funct3, i_memAddr[1:0]);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath updates and stall/fault
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        fault_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    req_d.addr     = i_memAddr;
                    req_d.data_lo  = i_writeData[15:0];
                    req_d.funct3   = i_funct3;
                    req_d.is_store = in_store;
                end
                if (i_ctrlMEM != 2'b00) begin
                    if (!legal) begin
                        fault_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = '0;
                        if (in_store && (i_funct3 == F3_SW)) begin
                            wdata_d = i_writeData;
                            state_d = WR_REQ;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: begin
                stall_c = 1'b1;
                if (mem.ready) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem.rvalid) begin
                    stall_c = 1'b1;
                    if (req_q.is_store) begin
                        wdata_d = merge_c;
                        state_d = WR_REQ;
                    end else begin
                        rdata_d = load_c;
                        state_d = DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fault_c = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            WR_REQ: begin
                stall_c = 1'b1;
                if (mem.ready) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_readData = rdata_q;
    assign o_stall    = stall_c;
    assign o_fault    = fault_c;
    assign mem.valid  = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem.we     = (state_q == WR_REQ);
    assign mem.addr   = {req_q.addr[XLEN-1:2], 2'b00};
    assign mem.wdata  = wdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a hand-driven memory port.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [1:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] read_data;
    logic        stall;
    logic        fault;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_memAddr   (addr_in),
        .i_writeData (wdata_in),
        .i_ctrlMEM   (ctrl),
        .i_funct3    (f3),
        .o_readData  (read_data),
        .o_stall     (stall),
        .o_fault     (fault),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input string tag, input logic [31:0] a, input logic [2:0] fn,
                           input logic [31:0] word, input logic [31:0] exp);
        ctrl = 2'b10; f3 = fn; addr_in = a; bus.ready = 1'b1;
        #1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c0_fault"}, 32'(fault), 32'd0);
        step;
        chk({tag, "_c1_valid"}, 32'(bus.valid), 32'd1);
        chk({tag, "_c1_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_c1_addr"}, bus.addr, {a[31:2], 2'b00});
        step;
        bus.rvalid = 1'b1; bus.rdata = word;
        #1;
        chk({tag, "_c2_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c2_valid"}, 32'(bus.valid), 32'd0);
        step;
        bus.rvalid = 1'b0; ctrl = 2'b00;
        #1;
        chk({tag, "_c3_stall"}, 32'(stall), 32'd0);
        chk({tag, "_c3_data"}, read_data, exp);
        step;
    endtask

    task automatic store_rmw(input string tag, input logic [31:0] a, input logic [2:0] fn,
                             input logic [31:0] d, input logic [31:0] old, input logic [31:0] exp);
        ctrl = 2'b01; f3 = fn; addr_in = a; wdata_in = d; bus.ready = 1'b1;
        #1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
        step;
        chk({tag, "_rd_valid"}, 32'(bus.valid), 32'd1);
        chk({tag, "_rd_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_rd_addr"}, bus.addr, {a[31:2], 2'b00});
        step;
        bus.rvalid = 1'b1; bus.rdata = old;
        #1;
        chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
        step;
        bus.rvalid = 1'b0;
        #1;
        chk({tag, "_wr_valid"}, 32'(bus.valid), 32'd1);
        chk({tag, "_wr_we"}, 32'(bus.we), 32'd1);
        chk({tag, "_wr_addr"}, bus.addr, {a[31:2], 2'b00});
        chk({tag, "_wr_data"}, bus.wdata, exp);
        step;
        ctrl = 2'b00;
        #1;
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done_valid"}, 32'(bus.valid), 32'd0);
        step;
    endtask

    task automatic fault_op(input string tag, input logic [1:0] c, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] exp_rd);
        ctrl = c; f3 = fn; addr_in = a;
        #1;
        chk({tag, "_fault"}, 32'(fault), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        step;
        ctrl = 2'b00;
        #1;
        chk({tag, "_after_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_after_fault"}, 32'(fault), 32'd0);
        chk({tag, "_after_data"}, read_data, exp_rd);
        step;
    endtask

    initial begin
        rst_n = 1'b0; ctrl = 2'b00; f3 = 3'd0; addr_in = '0; wdata_in = '0;
        bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        step; step;
        rst_n = 1'b1;
        #1;
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        step;

        // SW: IDLE (stall), WR_REQ (stall, handshake), DONE
        ctrl = 2'b01; f3 = 3'd2; addr_in = 32'h100; wdata_in = 32'hDEADBEEF; bus.ready = 1'b1;
        #1;
        chk("sw_c0_stall", 32'(stall), 32'd1);
        chk("sw_c0_fault", 32'(fault), 32'd0);
        chk("sw_c0_valid", 32'(bus.valid), 32'd0);
        step;
        chk("sw_c1_valid", 32'(bus.valid), 32'd1);
        chk("sw_c1_we", 32'(bus.we), 32'd1);
        chk("sw_c1_addr", bus.addr, 32'h100);
        chk("sw_c1_wdata", bus.wdata, 32'hDEADBEEF);
        chk("sw_c1_stall", 32'(stall), 32'd1);
        step;
        ctrl = 2'b00;
        #1;
        chk("sw_c2_stall", 32'(stall), 32'd0);
        chk("sw_c2_valid", 32'(bus.valid), 32'd0);
        step;

        load_op("lb", 32'h103, 3'd0, 32'h80FF_0000, 32'hFFFF_FF80);
        load_op("lbu", 32'h103, 3'd4, 32'h80FF_0000, 32'h0000_0080);
        load_op("lh", 32'h102, 3'd1, 32'h8001_7FFF, 32'hFFFF_8001);
        load_op("lhu", 32'h100, 3'd5, 32'h8001_7FFF, 32'h0000_7FFF);

        store_rmw("sh", 32'h202, 3'd1, 32'h0000_1234, 32'hAAAA_BBBB, 32'h1234_BBBB);
        store_rmw("sb", 32'h301, 3'd0, 32'hFFFF_FF55, 32'h1122_3344, 32'h1122_5544);
        chk("rmw_rdata_hold", read_data, 32'h0000_7FFF);

        fault_op("lw_mis", 2'b10, 3'd2, 32'h101, 32'h0000_7FFF);
        fault_op("ld_f3", 2'b10, 3'd3, 32'h100, 32'h0000_7FFF);
        fault_op("ctrl11", 2'b11, 3'd2, 32'h100, 32'h0000_7FFF);
        fault_op("lh_mis", 2'b10, 3'd1, 32'h103, 32'h0000_7FFF);
        fault_op("st_f3", 2'b01, 3'd4, 32'h100, 32'h0000_7FFF);

        // LW with ready low for 3 cycles, then rvalid after 5 empty RD_WAIT cycles
        ctrl = 2'b10; f3 = 3'd2; addr_in = 32'h300; bus.ready = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("slow_req_valid", 32'(bus.valid), 32'd1);
            chk("slow_req_addr", bus.addr, 32'h300);
            step;
        end
        bus.ready = 1'b1;
        step;
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("slow_wait_stall", 32'(stall), 32'd1);
            chk("slow_wait_fault", 32'(fault), 32'd0);
            step;
        end
        bus.rvalid = 1'b1; bus.rdata = 32'h1122_3344;
        step;
        bus.rvalid = 1'b0; ctrl = 2'b00;
        #1;
        chk("slow_done_stall", 32'(stall), 32'd0);
        chk("slow_data", read_data, 32'h1122_3344);
        step;

        // Timeout: fault on the 8th RD_WAIT cycle, then IDLE; late rvalid ignored
        ctrl = 2'b10; f3 = 3'd2; addr_in = 32'h400; bus.ready = 1'b1;
        step;
        step;
        for (int w = 1; w <= 8; w++) begin
            if (w == 8) ctrl = 2'b00;
            #1;
            chk("to_fault", 32'(fault), (w == 8) ? 32'd1 : 32'd0);
            chk("to_stall", 32'(stall), (w == 8) ? 32'd0 : 32'd1);
            step;
        end
        bus.rvalid = 1'b1; bus.rdata = 32'h5555_AAAA;
        #1;
        chk("to_idle_valid", 32'(bus.valid), 32'd0);
        chk("to_idle_stall", 32'(stall), 32'd0);
        chk("to_idle_fault", 32'(fault), 32'd0);
        step;
        bus.rvalid = 1'b0;
        #1;
        chk("to_late_rdata", read_data, 32'h1122_3344);
        chk("to_late_valid", 32'(bus.valid), 32'd0);
        step;

        // Reset during RD_WAIT aborts the access
        ctrl = 2'b10; f3 = 3'd2; addr_in = 32'h500;
        step;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1; ctrl = 2'b00;
        #1;
        chk("mid_rst_valid", 32'(bus.valid), 32'd0);
        chk("mid_rst_rdata", read_data, 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        step;
        load_op("lw_post", 32'h104, 3'd2, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit in the MEM stage: the initiator side of the word-addressed data-memory port. It converts pipeline load/store controls (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned valid/ready transactions, with a read-modify-write sequence for sub-word stores. It sign- or zero-extends load data and stalls the pipeline until each access completes. Misaligned, illegal or timed-out accesses are reported as faults.

## Interface
- `TIMEOUT_CYCLES`, 256: maximum cycles spent in RD_WAIT before a fault is raised; must be ≥2.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset_n`  in  1  reset: synchronous, active-low.
- `i_memAddr`  in  32  byte address from EX/MEM.
- `i_writeData`  in  32  store data; sub-word stores use the low bits.
- `i_ctrlMEM`  in  2  [1]=Mem-Read, [0]=Mem-Write.
- `i_funct3`  in  3  RV32I load/store width and sign encoding.
- `o_readData`  out  32  extended load result.
- `o_stall`  out  1  holds the pipeline while an access is in flight.
- `o_fault`  out  1  one-cycle pulse: misaligned, illegal or timeout.
- `o_memValid`  out  1  request valid toward memory.
- `i_memReady`  in  1  memory accepts the request when it and `o_memValid` are both 1.
- `o_memWe`  out  1  1 = write request.
- `o_memAddr`  out  32  word address; bits [1:0] are always 0.
- `o_memWData`  out  32  full word to write.
- `i_memRValid`  in  1  read data valid; arrives ≥1 cycle after acceptance.
- `i_memRData`  in  32  read word.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE behaviour:
  - If `i_ctrlMEM` is 00, do nothing.
  - If exactly one bit of `i_ctrlMEM` is set, capture addr, data, funct3 and op.
  - Illegal-access checks run first:
    - funct3 illegal (loads: 3, 6, 7; stores: >2) → fault;
    - `i_ctrlMEM`=11 → fault;
    - misaligned (H/HU with addr[0]=1, W with addr[1:0]≠0) → fault.
  - On a fault: no memory request, no stall, stay in IDLE, `o_readData` unchanged.
- IDLE transitions on a legal access:
  - load → RD_REQ;
  - SW → WR_REQ;
  - SB/SH → RD_REQ (read phase of read-modify-write).
- RD_REQ: `o_memValid`=1, `o_memWe`=0; on handshake → RD_WAIT.
- RD_WAIT, on `i_memRValid`:
  - load: extract the byte/half selected by addr[1:0], extend it, register into `o_readData`, → DONE;
  - SB/SH: merge the store data into the returned word at the byte lanes selected by addr[1:0], register into `o_memWData`, → WR_REQ.
- WR_REQ: `o_memValid`=1, `o_memWe`=1; on handshake → DONE. Write completion is the handshake itself; no response is expected.
- DONE: `o_stall`=0 for one cycle so the pipeline advances; unconditionally → IDLE.
- Timeout: a counter increments each cycle in RD_WAIT and clears on entry. At `TIMEOUT_CYCLES` with no `i_memRValid`: raise fault, go to IDLE, `o_stall`=0 that cycle.
- `i_memRValid` in any state other than RD_WAIT is ignored. This covers stale responses after a reset or a timeout.
- `o_stall` is combinational:
  - 1 in RD_REQ, RD_WAIT and WR_REQ;
  - 1 in IDLE when a legal access is presented;
  - 0 otherwise.
- `o_memAddr` = {captured addr[31:2], 2'b00}, held stable while `o_memValid`=1. `o_memValid` never drops before its handshake.

## Timing
- Reset (`i_reset_n`=0 at a rising edge): state→IDLE, counter→0. Outputs after reset:
  - `o_readData`=0, `o_memWData`=0, `o_memAddr`=0;
  - `o_memValid`=0, `o_memWe`=0;
  - `o_fault`=0; `o_stall`=0 once in IDLE with no access presented.
- Reset mid-transaction aborts it immediately; `o_memValid` is 0 in the next cycle.
- SW with ready=1: stall in cycles 0–1, DONE in cycle 2. Total 3 cycles.
- LW with ready=1 and rvalid one cycle after acceptance: IDLE c0, RD_REQ c1, RD_WAIT c2, DONE c3. `o_readData` is valid from c3 and holds until the next completed load.
- SB/SH: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE. Minimum 5 cycles.
- `i_memReady`=0 adds one cycle per wait cycle in RD_REQ or WR_REQ. There is no timeout on ready.
- `o_fault` is asserted in the same cycle the faulting access is presented in IDLE, or in the timeout cycle.

## Structure
- `mem_pkg` holds:
  - the funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2);
  - the `lsu_state_t` enum;
  - the `CTRL_RD`/`CTRL_WR` bit indices.
- Sub-module `mem_lsu_align` is purely combinational and contains the load extract/extend and the store lane merge, so both can be unit-tested in isolation.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready=1 → one write handshake with addr 0x100, wdata 0xDEADBEEF; stall exactly 2 cycles; no fault.
- LB addr 0x103, memory word 0x80FF_0000 returned → `o_readData`=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH addr 0x202, data 0x1234, old word 0xAAAA_BBBB → read handshake, then write 0x1234_BBBB to 0x200.
- LW addr 0x101 → `o_fault` pulses in the same cycle, `o_memValid` stays 0, `o_stall`=0, `o_readData` unchanged. Repeat with funct3=3 and with `i_ctrlMEM`=11.
- LW with ready held low for 3 cycles, then rvalid after 5 more → no timeout, correct data. With `TIMEOUT_CYCLES`=8 and no rvalid → fault on the 8th RD_WAIT cycle, then IDLE; a late rvalid is ignored.
- Reset asserted during RD_WAIT → next cycle IDLE, `o_memValid`=0, `o_readData`=0. A following LW completes normally.
